// File: rtl/led_fb_scheduler.sv
// Double-buffered 1-bpp frame store for the LED panel scanner.
// Two writers share the back buffer; swap and clear never disturb the displayed frame.
module led_fb_scheduler #(
  parameter int   COLS     = 16,
  parameter int   ROWS     = 8,
  parameter logic CLR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic [3:0] a_col,
  input  logic [2:0] a_row,
  input  logic       a_data,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [3:0] b_col,
  input  logic [2:0] b_row,
  input  logic       b_data,
  output logic       b_ack,
  input  logic       clr_req,
  input  logic       swap_req,
  input  logic       frame_sync,
  input  logic [3:0] rd_col,
  input  logic [2:0] rd_row,
  output logic       rd_data,
  output logic       swap_pending,
  output logic       swap_done,
  output logic       busy
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_r;
  logic            fs_r;
  logic            last_grant_r;
  logic            swap_pending_r;
  logic            swap_done_r;
  logic            busy_r;
  logic            rd_data_r;
  logic [3:0]      clr_col_r;
  logic [ROWS-1:0] mem_r [2][COLS];

  logic swap_cycle_s;
  logic grant_a_s;
  logic grant_b_s;
  logic back_s;
  logic a_in_range_s;
  logic b_in_range_s;
  logic rd_in_range_s;

  // Swap detection, address range checks and round-robin grant
  always_comb begin
    swap_cycle_s  = frame_sync & swap_pending_r & (state_r == ARB);
    back_s        = ~fs_r;
    a_in_range_s  = (int'(a_col) < COLS) && (int'(a_row) < ROWS);
    b_in_range_s  = (int'(b_col) < COLS) && (int'(b_row) < ROWS);
    rd_in_range_s = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);
    grant_a_s     = 1'b0;
    grant_b_s     = 1'b0;
    if ((state_r == ARB) && !swap_cycle_s) begin
      // last_grant_r = 1 means B went last, so A wins a tie
      grant_a_s = a_req & (~b_req | last_grant_r);
      grant_b_s = b_req & (~a_req | ~last_grant_r);
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Control FSM: clear sequencing, swap scheduling and arbitration history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ARB;
      fs_r           <= 1'b0;
      last_grant_r   <= 1'b1;
      swap_pending_r <= 1'b0;
      swap_done_r    <= 1'b0;
      busy_r         <= 1'b0;
      clr_col_r      <= 4'd0;
    end else begin
      swap_done_r <= swap_cycle_s;
      if (swap_cycle_s) begin
        fs_r           <= ~fs_r;
        swap_pending_r <= 1'b0;
      end else if (swap_req) begin
        swap_pending_r <= 1'b1;
      end else begin
        swap_pending_r <= swap_pending_r;
      end

      if (grant_a_s) begin
        last_grant_r <= 1'b0;
      end else if (grant_b_s) begin
        last_grant_r <= 1'b1;
      end else begin
        last_grant_r <= last_grant_r;
      end

      // A clear coinciding with a swap starts here too, so it lands on the new back buffer
      case (state_r)
        ARB: begin
          if (clr_req) begin
            state_r   <= CLEAR;
            busy_r    <= 1'b1;
            clr_col_r <= 4'd0;
          end else begin
            state_r   <= ARB;
            busy_r    <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_col_r == 4'(COLS - 1)) begin
            state_r <= ARB;
            busy_r  <= 1'b0;
          end else begin
            clr_col_r <= clr_col_r + 4'd1;
          end
        end
        default: begin
          state_r <= ARB;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage: back-buffer writes/clears and registered front-buffer read
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++) begin
        mem_r[0][c] <= '0;
        mem_r[1][c] <= '0;
      end
      rd_data_r <= 1'b0;
    end else begin
      rd_data_r <= rd_in_range_s ? mem_r[fs_r][rd_col][rd_row] : 1'b0;
      if (state_r == CLEAR) begin
        mem_r[back_s][clr_col_r] <= {ROWS{CLR_INIT}};
      end else if (grant_a_s && a_in_range_s) begin
        mem_r[back_s][a_col][a_row] <= a_data;
      end else if (grant_b_s && b_in_range_s) begin
        mem_r[back_s][b_col][b_row] <= b_data;
      end else begin
        rd_data_r <= rd_in_range_s ? mem_r[fs_r][rd_col][rd_row] : 1'b0;
      end
    end
  end

  assign a_ack        = grant_a_s;
  assign b_ack        = grant_b_s;
  assign rd_data      = rd_data_r;
  assign swap_pending = swap_pending_r;
  assign swap_done    = swap_done_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_led_fb_scheduler.sv
// Bench for led_fb_scheduler: fixed vector table, directed corner sequences,
// and randomized traffic checked cycle by cycle against a frame-level model.
module tb_led_fb_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0, a_data = 1'b0, b_data = 1'b0;
  logic [3:0] a_col = 4'd0, b_col = 4'd0, rd_col = 4'd0;
  logic [2:0] a_row = 3'd0, b_row = 3'd0, rd_row = 3'd0;
  logic       clr_req = 1'b0, swap_req = 1'b0, frame_sync = 1'b0;
  logic       a_ack, b_ack, rd_data, swap_pending, swap_done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  led_fb_scheduler #(.COLS(16), .ROWS(8), .CLR_INIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_col(a_col), .a_row(a_row), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_col(b_col), .b_row(b_row), .b_data(b_data), .b_ack(b_ack),
    .clr_req(clr_req), .swap_req(swap_req), .frame_sync(frame_sync),
    .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data),
    .swap_pending(swap_pending), .swap_done(swap_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame-level model: two pixel planes, which plane is shown, and pending work.
  bit m_mem [2][16][8];
  int m_fs, m_last, m_clr_left;
  bit m_pend, m_done, m_rd;

  function automatic void model_reset();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 16; c++)
        for (int r = 0; r < 8; r++) m_mem[p][c][r] = 1'b0;
    m_fs = 0; m_last = 1; m_clr_left = 0;
    m_pend = 1'b0; m_done = 1'b0; m_rd = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare all outputs with the model, take the edge, advance the model.
  task automatic cycle();
    int  winner;
    bit  clearing, swapping;
    logic [5:0] exp;
    #1;
    clearing = (m_clr_left > 0);
    swapping = frame_sync && m_pend && !clearing;
    winner = 0;
    if (!clearing && !swapping) begin
      if (a_req && b_req) winner = (m_last == 1) ? 1 : 2;
      else if (a_req)     winner = 1;
      else if (b_req)     winner = 2;
    end
    exp = {winner == 1, winner == 2, m_rd, m_pend, m_done, clearing};
    chk("cycle_outputs", {26'd0, a_ack, b_ack, rd_data, swap_pending, swap_done, busy}, {26'd0, exp});
    @(posedge clk);
    m_rd = m_mem[m_fs][rd_col][rd_row];
    if (clearing) begin
      for (int r = 0; r < 8; r++) m_mem[1 - m_fs][16 - m_clr_left][r] = 1'b0;
      m_clr_left--;
    end else begin
      if (winner == 1)      m_mem[1 - m_fs][a_col][a_row] = a_data;
      else if (winner == 2) m_mem[1 - m_fs][b_col][b_row] = b_data;
      if (clr_req) m_clr_left = 16;
    end
    if (winner != 0) m_last = winner - 1;
    m_done = swapping;
    if (swapping) begin
      m_fs = 1 - m_fs;
      m_pend = 1'b0;
    end else if (swap_req) begin
      m_pend = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; b_req = 1'b0; clr_req = 1'b0; swap_req = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_px(input bit use_b, input logic [3:0] c, input logic [2:0] r, input logic d);
    bit got = 1'b0;
    if (use_b) begin b_req = 1'b1; b_col = c; b_row = r; b_data = d; end
    else       begin a_req = 1'b1; a_col = c; a_row = r; a_data = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      got = use_b ? b_ack : a_ack;
      cycle();
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("write_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    frame_sync = 1'b1;
    cycle();
    frame_sync = 1'b0;
    chk("swap_done_pulse", {31'd0, swap_done}, 32'd1);
    cycle();
  endtask

  task automatic read_px(input logic [3:0] c, input logic [2:0] r, output logic v);
    rd_col = c; rd_row = r;
    cycle();
    v = rd_data;
  endtask

  typedef struct {
    logic a_req; logic [3:0] a_col; logic [2:0] a_row; logic a_data;
    logic b_req; logic [3:0] b_col; logic [2:0] b_row; logic b_data;
    logic swap_req; logic frame_sync; logic [3:0] rd_col; logic [2:0] rd_row;
    logic [5:0] exp;   // {a_ack, b_ack, rd_data, swap_pending, swap_done, busy}
  } vec_t;

  function automatic vec_t mk(input int ar, ac, aw, ad, br, bc, bw, bd, sw, fy, rc, rr,
                              input logic [5:0] e);
    vec_t v;
    v.a_req = 1'(ar); v.a_col = 4'(ac); v.a_row = 3'(aw); v.a_data = 1'(ad);
    v.b_req = 1'(br); v.b_col = 4'(bc); v.b_row = 3'(bw); v.b_data = 1'(bd);
    v.swap_req = 1'(sw); v.frame_sync = 1'(fy); v.rd_col = 4'(rc); v.rd_row = 3'(rr);
    v.exp = e;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    logic v;
    int busy_cnt, ack_in_busy, done_cnt, ones;
    bit a_hold, b_hold;

    tbl[0]  = mk(1,0,0,1, 1,1,1,1, 0,0, 0,0, 6'b100000);
    tbl[1]  = mk(1,2,2,1, 1,1,1,1, 0,0, 0,0, 6'b010000);
    tbl[2]  = mk(1,2,2,1, 1,4,4,1, 0,0, 0,0, 6'b100000);
    tbl[3]  = mk(1,6,6,1, 1,4,4,1, 0,0, 0,0, 6'b010000);
    tbl[4]  = mk(1,3,5,1, 0,0,0,0, 1,0, 0,0, 6'b100000);
    tbl[5]  = mk(0,0,0,0, 0,0,0,0, 0,1, 3,5, 6'b000100);
    tbl[6]  = mk(0,0,0,0, 0,0,0,0, 0,0, 3,5, 6'b000010);
    tbl[7]  = mk(0,0,0,0, 0,0,0,0, 0,0, 4,4, 6'b001000);
    tbl[8]  = mk(0,0,0,0, 0,0,0,0, 0,0, 6,6, 6'b001000);
    tbl[9]  = mk(0,0,0,0, 0,0,0,0, 0,0, 0,0, 6'b000000);
    tbl[10] = mk(0,0,0,0, 0,0,0,0, 0,0, 0,1, 6'b001000);
    tbl[11] = mk(0,0,0,0, 0,0,0,0, 0,0, 1,1, 6'b000000);
    tbl[12] = mk(0,0,0,0, 0,0,0,0, 0,0, 2,2, 6'b001000);
    tbl[13] = mk(0,0,0,0, 0,0,0,0, 0,0, 0,0, 6'b001000);

    do_reset();
    #1;
    chk("reset_outputs", {26'd0, a_ack, b_ack, rd_data, swap_pending, swap_done, busy}, 32'd0);
    @(negedge clk);

    // Arbitration order, first write + swap, read-back latency
    for (int i = 0; i < 14; i++) begin
      a_req = tbl[i].a_req; a_col = tbl[i].a_col; a_row = tbl[i].a_row; a_data = tbl[i].a_data;
      b_req = tbl[i].b_req; b_col = tbl[i].b_col; b_row = tbl[i].b_row; b_data = tbl[i].b_data;
      swap_req = tbl[i].swap_req; frame_sync = tbl[i].frame_sync;
      rd_col = tbl[i].rd_col; rd_row = tbl[i].rd_row;
      #1;
      chk($sformatf("vec%0d", i), {26'd0, a_ack, b_ack, rd_data, swap_pending, swap_done, busy},
          {26'd0, tbl[i].exp});
      cycle();
    end
    idle_inputs();

    // Fill the back buffer with ones, clear it, swap during CLEAR is deferred
    do_reset();
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 8; r++) write_px(1'b0, 4'(c), 3'(r), 1'b1);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    busy_cnt = 0; ack_in_busy = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      a_req = (i < 16); a_col = 4'd0; a_row = 3'd0; a_data = 1'b1;
      swap_req = (i == 1);
      frame_sync = (i == 5);
      #1;
      busy_cnt += int'(busy);
      if (busy && a_ack) ack_in_busy++;
      done_cnt += int'(swap_done);
      cycle();
    end
    idle_inputs();
    chk("clear_busy_cycles", busy_cnt, 32'd16);
    chk("clear_no_acks", ack_in_busy, 32'd0);
    chk("clear_no_swap", done_cnt, 32'd0);
    chk("clear_swap_still_pending", {31'd0, swap_pending}, 32'd1);
    frame_sync = 1'b1;
    cycle();
    frame_sync = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      done_cnt += int'(swap_done);
      cycle();
    end
    chk("deferred_single_swap", done_cnt, 32'd1);
    chk("deferred_pending_clear", {31'd0, swap_pending}, 32'd0);
    ones = 0;
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 8; r++) begin
        read_px(4'(c), 3'(r), v);
        ones += int'(v);
      end
    chk("cleared_frame_ones", ones, 32'd0);

    // Write held across the swap cycle goes to the new back buffer
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    a_req = 1'b1; a_col = 4'd5; a_row = 3'd2; a_data = 1'b1;
    frame_sync = 1'b1;
    #1;
    chk("swap_cycle_ack_withheld", {31'd0, a_ack}, 32'd0);
    cycle();
    frame_sync = 1'b0;
    #1;
    chk("post_swap_ack", {31'd0, a_ack}, 32'd1);
    cycle();
    a_req = 1'b0;
    read_px(4'd5, 3'd2, v);
    chk("displayed_untouched", {31'd0, v}, 32'd0);
    do_swap();
    read_px(4'd5, 3'd2, v);
    chk("new_back_written", {31'd0, v}, 32'd1);

    // Corner addresses, then reset in the middle of a clear with a swap pending
    write_px(1'b1, 4'd15, 3'd7, 1'b1);
    write_px(1'b1, 4'd2, 3'd0, 1'b1);
    do_swap();
    read_px(4'd15, 3'd7, v);
    chk("corner_15_7", {31'd0, v}, 32'd1);
    read_px(4'd2, 3'd0, v);
    chk("corner_2_0", {31'd0, v}, 32'd1);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    cycle();
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    do_reset();
    #1;
    chk("reset_mid_clear", {29'd0, busy, swap_pending, swap_done}, 32'd0);
    @(negedge clk);
    ones = 0;
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 8; r++) begin
        read_px(4'(c), 3'(r), v);
        ones += int'(v);
      end
    chk("reset_frame_ones", ones, 32'd0);

    // Randomized traffic against the model; requesters hold until acked
    a_hold = 1'b0; b_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!a_hold && $urandom_range(0, 2) == 0) begin
        a_hold = 1'b1; a_col = 4'($urandom); a_row = 3'($urandom); a_data = 1'($urandom);
      end
      if (!b_hold && $urandom_range(0, 2) == 0) begin
        b_hold = 1'b1; b_col = 4'($urandom); b_row = 3'($urandom); b_data = 1'($urandom);
      end
      a_req = a_hold; b_req = b_hold;
      clr_req = ($urandom_range(0, 59) == 0);
      swap_req = ($urandom_range(0, 9) == 0);
      frame_sync = ($urandom_range(0, 7) == 0);
      rd_col = 4'($urandom); rd_row = 3'($urandom);
      #1;
      if (a_ack) a_hold = 1'b0;
      if (b_ack) b_hold = 1'b0;
      cycle();
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        a_hold = 1'b0; b_hold = 1'b0;
      end
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
